// File: rtl/regwb_seq.sv
// regwb_seq: serialises 8/16-bit write-back and pair inc/dec requests into byte writes
// on the register file write port. Define REGWB_OAMBUG_EN to add the oam_bug output.
module regwb_seq #(
  parameter logic [2:0] RESET_IDX = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_pair,
  input  logic [2:0]  req_idx,
  input  logic [15:0] req_data,
  output logic [1:0]  rdwn,
  input  logic [15:0] rdw,
  output logic [2:0]  wrn,
  output logic [7:0]  wr,
  output logic        we,
  output logic        busy,
  output logic        done
`ifdef REGWB_OAMBUG_EN
  ,
  output logic        oam_bug
`endif
);

  localparam logic [1:0] OP_WR16 = 2'd0;
  localparam logic [1:0] OP_INC16 = 2'd1;
  localparam logic [1:0] OP_DEC16 = 2'd2;
  localparam logic [1:0] OP_WR8 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t      state_p1;
  logic [1:0]  pair_p1;
  logic [7:0]  hi_p1;
  logic [15:0] acc_val_p0;

  // 16-bit value to be written back; inc/dec wrap modulo 2^16.
  function automatic logic [15:0] wb_value(input logic [1:0] op, input logic [15:0] src,
                                           input logic [15:0] data);
    logic [15:0] r;
    case (op)
      OP_INC16: r = src + 16'd1;
      OP_DEC16: r = src - 16'd1;
      default:  r = data;
    endcase
    return r;
  endfunction

  assign acc_val_p0 = wb_value(req_op, rdw, req_data);
  assign req_ready  = (state_p1 == IDLE);
  assign busy       = ~req_ready;
  assign rdwn       = req_ready ? req_pair : pair_p1;

  // accept -> WR_LO (low byte) -> WR_HI (high byte or WR8 byte, with done)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      pair_p1  <= 2'd0;
      hi_p1    <= 8'd0;
      we       <= 1'b0;
      wr       <= 8'd0;
      wrn      <= RESET_IDX;
      done     <= 1'b0;
    end else begin
      case (state_p1)
        IDLE: begin
          we   <= 1'b0;
          done <= 1'b0;
          if (req_valid) begin
            pair_p1 <= req_pair;
            we      <= 1'b1;
            if (req_op == OP_WR8) begin
              state_p1 <= WR_HI;
              wrn      <= req_idx;
              wr       <= req_data[7:0];
              done     <= 1'b1;
            end else begin
              state_p1 <= WR_LO;
              wrn      <= {req_pair, 1'b1};
              wr       <= acc_val_p0[7:0];
              hi_p1    <= acc_val_p0[15:8];
            end
          end
        end
        WR_LO: begin
          state_p1 <= WR_HI;
          we       <= 1'b1;
          wrn      <= {pair_p1, 1'b0};
          wr       <= hi_p1;
          done     <= 1'b1;
        end
        WR_HI: begin
          state_p1 <= IDLE;
          we       <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state_p1 <= IDLE;
          we       <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGWB_OAMBUG_EN
  // Flags inc/dec of a pair pointing into FE00-FEFF, visible during the WR_LO cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oam_bug <= 1'b0;
    end else begin
      oam_bug <= req_ready && req_valid && (req_op == OP_INC16 || req_op == OP_DEC16) &&
                 (rdw[15:8] == 8'hFE);
    end
  end
`endif

endmodule

// File: tb/tb_regwb_seq.sv
// Randomised and directed bench for regwb_seq with a byte-array register file model.
module tb_regwb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [2:0]  req_idx;
  logic [15:0] req_data;
  logic [1:0]  rdwn;
  logic [15:0] rdw;
  logic [2:0]  wrn;
  logic [7:0]  wr;
  logic        we;
  logic        busy;
  logic        done;
`ifdef REGWB_OAMBUG_EN
  logic        oam_bug;
`endif

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] rf [8];
  int         wcnt = 0;
  logic [7:0] exp_rf [8];

  logic        acc_ready;
  logic [1:0]  acc_rdwn;
  logic [15:0] acc_rdw;
  logic        ob_we [3];
  logic [2:0]  ob_wrn [3];
  logic [7:0]  ob_wr [3];
  logic        ob_done [3];
  logic        ob_ready [3];
  logic        ob_busy [3];
  logic [1:0]  ob_rdwn [3];
  logic        ob_oam [3];

  regwb_seq #(.RESET_IDX(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_pair(req_pair), .req_idx(req_idx), .req_data(req_data),
    .rdwn(rdwn), .rdw(rdw), .wrn(wrn), .wr(wr), .we(we), .busy(busy), .done(done)
`ifdef REGWB_OAMBUG_EN
    , .oam_bug(oam_bug)
`endif
  );

  always #5 clk = ~clk;

  assign rdw = {rf[{rdwn, 1'b0}], rf[{rdwn, 1'b1}]};

  always @(posedge clk) begin
    if (we) begin
      rf[wrn] <= wr;
      wcnt <= wcnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issue one request (called just after a falling edge) and record the following cycles.
  task automatic send(input logic [1:0] op, input logic [1:0] pair, input logic [2:0] idx,
                      input logic [15:0] data, input bit hold);
    int n;
    n = (op == 2'd3) ? 2 : 3;
    req_valid = 1'b1; req_op = op; req_pair = pair; req_idx = idx; req_data = data;
    #1;
    acc_ready = req_ready; acc_rdwn = rdwn; acc_rdw = rdw;
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      ob_we[c] = we; ob_wrn[c] = wrn; ob_wr[c] = wr; ob_done[c] = done;
      ob_ready[c] = req_ready; ob_busy[c] = busy; ob_rdwn[c] = rdwn;
`ifdef REGWB_OAMBUG_EN
      ob_oam[c] = oam_bug;
`else
      ob_oam[c] = 1'b0;
`endif
      if (!hold && c == 0) req_valid = 1'b0;
      if (hold && c < n - 1) begin
        req_op = 2'($urandom_range(3)); req_pair = 2'($urandom_range(3));
        req_idx = 3'($urandom_range(7)); req_data = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] h_before;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_pair = 2'd0; req_idx = 3'd0; req_data = 16'd0;
    repeat (2) @(negedge clk);
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0h want 0", we); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0h want 0", done); end
    n_tests++; if (wrn !== 3'd0) begin n_fail++; $display("FAIL reset_wrn got %0h want 0", wrn); end
    n_tests++; if (wr !== 8'd0) begin n_fail++; $display("FAIL reset_wr got %0h want 0", wr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    send(2'd0, 2'd2, 3'd0, 16'h1234, 1'b0);
    h_before = rf[4];
    // Start a WR16 to HL and pull reset in the middle of its WR_LO cycle.
    req_valid = 1'b1; req_op = 2'd0; req_pair = 2'd2; req_data = 16'hBEEF;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    n_tests++; if (we !== 1'b1) begin n_fail++; $display("FAIL abort_pre_we got %0h want 1", we); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL abort_we got %0h want 0", we); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %0h want 0", done); end
    n_tests++; if (wrn !== 3'd0) begin n_fail++; $display("FAIL abort_wrn got %0h want 0", wrn); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %0h want 1", req_ready); end
    n_tests++; if (rf[4] !== h_before) begin n_fail++; $display("FAIL abort_hi_byte got %0h want %0h", rf[4], h_before); end
    @(negedge clk);
  endtask

  task automatic test_wr16();
    send(2'd0, 2'd2, 3'd0, 16'h8001, 1'b0);
    n_tests++; if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL wr16_ready_at_accept got %0h want 1", acc_ready); end
    n_tests++; if (acc_rdwn !== 2'd2) begin n_fail++; $display("FAIL wr16_rdwn_idle got %0h want 2", acc_rdwn); end
    n_tests++; if ({ob_we[0], ob_wrn[0], ob_wr[0], ob_done[0]} !== {1'b1, 3'd5, 8'h01, 1'b0})
      begin n_fail++; $display("FAIL wr16_lo got we=%0h wrn=%0h wr=%0h done=%0h want 1 5 01 0", ob_we[0], ob_wrn[0], ob_wr[0], ob_done[0]); end
    n_tests++; if ({ob_busy[0], ob_rdwn[0]} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL wr16_busy_rdwn got %0h %0h want 1 2", ob_busy[0], ob_rdwn[0]); end
    n_tests++; if ({ob_we[1], ob_wrn[1], ob_wr[1], ob_done[1]} !== {1'b1, 3'd4, 8'h80, 1'b1})
      begin n_fail++; $display("FAIL wr16_hi got we=%0h wrn=%0h wr=%0h done=%0h want 1 4 80 1", ob_we[1], ob_wrn[1], ob_wr[1], ob_done[1]); end
    n_tests++; if ({ob_ready[2], ob_we[2], ob_done[2]} !== 3'b100) begin n_fail++; $display("FAIL wr16_idle got ready=%0h we=%0h done=%0h want 1 0 0", ob_ready[2], ob_we[2], ob_done[2]); end
    n_tests++; if ({rf[4], rf[5]} !== 16'h8001) begin n_fail++; $display("FAIL wr16_hl got %0h want 8001", {rf[4], rf[5]}); end
  endtask

  task automatic test_incdec();
    send(2'd0, 2'd3, 3'd0, 16'hFFFF, 1'b0);
    send(2'd1, 2'd3, 3'd0, 16'h5A5A, 1'b0);
    n_tests++; if (acc_rdw !== 16'hFFFF) begin n_fail++; $display("FAIL inc_src got %0h want ffff", acc_rdw); end
    n_tests++; if ({ob_we[0], ob_wrn[0], ob_wr[0], ob_we[1], ob_wrn[1], ob_wr[1]} !== {1'b1, 3'd7, 8'h00, 1'b1, 3'd6, 8'h00})
      begin n_fail++; $display("FAIL inc_wrap got %0h/%0h %0h/%0h want 7/00 6/00", ob_wrn[0], ob_wr[0], ob_wrn[1], ob_wr[1]); end
    send(2'd0, 2'd0, 3'd0, 16'h0000, 1'b0);
    send(2'd2, 2'd0, 3'd0, 16'h1111, 1'b0);
    n_tests++; if ({ob_we[0], ob_wrn[0], ob_wr[0], ob_we[1], ob_wrn[1], ob_wr[1]} !== {1'b1, 3'd1, 8'hFF, 1'b1, 3'd0, 8'hFF})
      begin n_fail++; $display("FAIL dec_wrap got %0h/%0h %0h/%0h want 1/ff 0/ff", ob_wrn[0], ob_wr[0], ob_wrn[1], ob_wr[1]); end
    n_tests++; if (ob_done[1] !== 1'b1) begin n_fail++; $display("FAIL dec_done got %0h want 1", ob_done[1]); end
  endtask

  task automatic test_wr8();
    int w0;
    w0 = wcnt;
    send(2'd3, 2'($urandom_range(3)), 3'd3, 16'h12A5, 1'b0);
    n_tests++; if ({ob_we[0], ob_wrn[0], ob_wr[0], ob_done[0]} !== {1'b1, 3'd3, 8'hA5, 1'b1})
      begin n_fail++; $display("FAIL wr8_write got we=%0h wrn=%0h wr=%0h done=%0h want 1 3 a5 1", ob_we[0], ob_wrn[0], ob_wr[0], ob_done[0]); end
    n_tests++; if ({ob_ready[1], ob_we[1]} !== 2'b10) begin n_fail++; $display("FAIL wr8_idle got ready=%0h we=%0h want 1 0", ob_ready[1], ob_we[1]); end
    n_tests++; if (wcnt - w0 !== 1) begin n_fail++; $display("FAIL wr8_pulses got %0d want 1", wcnt - w0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    send(2'd0, 2'd1, 3'd0, 16'h00FF, 1'b0);
    w0 = wcnt;
    send(2'd1, 2'd1, 3'd0, 16'h0000, 1'b1);
    n_tests++; if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %0h want 1", acc_ready); end
    n_tests++; if ({rf[2], rf[3]} !== 16'h0100) begin n_fail++; $display("FAIL b2b_de1 got %0h want 0100", {rf[2], rf[3]}); end
    n_tests++; if (ob_ready[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready got %0h want 0", ob_ready[1]); end
    send(2'd1, 2'd1, 3'd0, 16'h0000, 1'b1);
    req_valid = 1'b0;
    n_tests++; if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got %0h want 1", acc_ready); end
    n_tests++; if (acc_rdw !== 16'h0100) begin n_fail++; $display("FAIL b2b_src2 got %0h want 0100", acc_rdw); end
    n_tests++; if ({rf[2], rf[3]} !== 16'h0101) begin n_fail++; $display("FAIL b2b_de2 got %0h want 0101", {rf[2], rf[3]}); end
    n_tests++; if (wcnt - w0 !== 4) begin n_fail++; $display("FAIL b2b_writes got %0d want 4", wcnt - w0); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  op, pair;
    logic [2:0]  idx;
    logic [15:0] data, src, res;
    logic [2:0]  ew_idx [2];
    logic [7:0]  ew_val [2];
    int          nw;
    bit          hold;
    for (int p = 0; p < 4; p++) begin
      data = 16'($urandom);
      send(2'd0, 2'(p), 3'd0, data, 1'b0);
      exp_rf[2*p] = data[15:8]; exp_rf[2*p+1] = data[7:0];
    end
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(3)); pair = 2'($urandom_range(3)); idx = 3'($urandom_range(7));
      data = 16'($urandom); hold = ($urandom_range(1) == 1);
      if ($urandom_range(3) == 0) data = {8'hFF, 8'hFF};
      src = {exp_rf[2*pair], exp_rf[2*pair+1]};
      case (op)
        2'd1: res = 16'((int'(src) + 1) % 65536);
        2'd2: res = 16'((int'(src) + 65535) % 65536);
        default: res = data;
      endcase
      if (op == 2'd3) begin
        nw = 1; ew_idx[0] = idx; ew_val[0] = data[7:0];
      end else begin
        nw = 2;
        ew_idx[0] = 3'(2*pair + 1); ew_val[0] = res[7:0];
        ew_idx[1] = 3'(2*pair);     ew_val[1] = res[15:8];
      end
      send(op, pair, idx, data, hold);
      for (int k = 0; k < nw; k++) begin
        exp_rf[ew_idx[k]] = ew_val[k];
        n_tests++;
        if ({ob_we[k], ob_wrn[k], ob_wr[k], ob_done[k]} !== {1'b1, ew_idx[k], ew_val[k], (k == nw - 1)})
          begin n_fail++; $display("FAIL rand%0d_w%0d got we=%0h wrn=%0h wr=%0h done=%0h want 1 %0h %0h %0h", it, k, ob_we[k], ob_wrn[k], ob_wr[k], ob_done[k], ew_idx[k], ew_val[k], (k == nw - 1)); end
      end
      n_tests++;
      if ({ob_ready[nw], ob_we[nw], ob_done[nw]} !== 3'b100)
        begin n_fail++; $display("FAIL rand%0d_idle got ready=%0h we=%0h done=%0h want 1 0 0", it, ob_ready[nw], ob_we[nw], ob_done[nw]); end
      for (int r = 0; r < 8; r++) begin
        n_tests++;
        if (rf[r] !== exp_rf[r]) begin n_fail++; $display("FAIL rand%0d_rf%0d got %0h want %0h", it, r, rf[r], exp_rf[r]); end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef REGWB_OAMBUG_EN
  task automatic test_oambug();
    send(2'd0, 2'd2, 3'd0, 16'hFE10, 1'b0);
    send(2'd1, 2'd2, 3'd0, 16'h0000, 1'b0);
    n_tests++; if ({ob_oam[0], ob_oam[1]} !== 2'b10) begin n_fail++; $display("FAIL oam_fe10 got %0h %0h want 1 0", ob_oam[0], ob_oam[1]); end
    send(2'd0, 2'd2, 3'd0, 16'hFF00, 1'b0);
    send(2'd1, 2'd2, 3'd0, 16'h0000, 1'b0);
    n_tests++; if ({ob_oam[0], ob_oam[1]} !== 2'b00) begin n_fail++; $display("FAIL oam_ff00 got %0h %0h want 0 0", ob_oam[0], ob_oam[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_wr16();
    test_incdec();
    test_wr8();
    test_back_to_back();
    test_random();
`ifdef REGWB_OAMBUG_EN
    test_oambug();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regwb_seq.md
Name: regwb_seq

Overview:
- Write-back sequencer directly upstream of the CPU register file (BCDEHLSP, 8-bit write port).
- Accepts 8-bit and 16-bit write-back requests from the CPU control path, including 16-bit increment/decrement (IDU) of a register pair.
- Serialises each request into one or two 8-bit writes on the register file write port.
- Reads the current pair value through the register file's 16-bit read port for inc/dec.

Parameters:
- RESET_IDX, 3'd0, value driven on wrn during and after reset until the first write.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; transfer when req_valid & req_ready
- req_op  in  2  0=WR16, 1=INC16, 2=DEC16, 3=WR8
- req_pair  in  2  pair for 16-bit ops: 0=BC, 1=DE, 2=HL, 3=SP
- req_idx  in  3  register index for WR8 (0=B … 5=L, 6=SPH, 7=SPL)
- req_data  in  16  WR16 data; WR8 uses [7:0]
- rdwn  out  2  pair select to register file 16-bit read port
- rdw  in  16  pair value from register file (combinational)
- wrn  out  3  register file write index
- wr  out  8  register file write data
- we  out  1  register file write enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse coincident with the final write of a request

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; we=0, wr=0, wrn=RESET_IDX, done=0.
  - Internal pair/result registers cleared.
  - Reset mid-request aborts it; remaining bytes are never written.
- FSM: IDLE, WR_LO, WR_HI. req_ready = (state==IDLE); busy = !req_ready.
- rdwn:
  - IDLE: req_pair (combinational).
  - Otherwise: the latched pair.
- Accept at edge E (IDLE, req_valid=1):
  - WR16: result = req_data.
  - INC16: result = rdw + 1, modulo 2^16 (FFFF→0000).
  - DEC16: result = rdw − 1, modulo 2^16 (0000→FFFF).
  - WR8: byte = req_data[7:0], index = req_idx; go to WR_HI directly.
  - 16-bit ops go to WR_LO.
- WR_LO (cycle after E): we=1, wrn={pair,1'b1}, wr=result[7:0]; next state WR_HI.
- WR_HI:
  - 16-bit: we=1, wrn={pair,1'b0}, wr=result[15:8].
  - WR8: we=1, wrn=req_idx latched, wr=byte.
  - done=1; next state IDLE.
- we, wrn, wr, done are registered outputs, valid in the cycle named above.
- Latency:
  - 16-bit op: writes in cycles E+1 and E+2.
  - WR8: write in cycle E+1.
  - Next accept possible at the edge ending the done cycle + 1 (i.e. from IDLE).
- The read of rdw happens only at accept. Writes complete before re-entering IDLE, so a back-to-back INC16 on the same pair sees the updated value.
- IDLE: we=0, done=0; wrn/wr hold their last values.
- req_* are ignored when req_ready=0; no requests are lost or duplicated.

Optional Feature:
- Macro: REGWB_OAMBUG_EN.
- Defined:
  - Adds output oam_bug (1 bit; reset 0).
  - oam_bug pulses high for one cycle, coincident with WR_LO, when an INC16 or DEC16 source value (rdw at accept) lies in 16'hFE00–16'hFEFF.
  - Models the DMG OAM corruption trigger for the PPU.
- Undefined:
  - Port absent; no comparator logic.
  - All other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 mid-WR_LO → we=0, done=0, wrn=RESET_IDX immediately (asynchronous); after release req_ready=1, and the aborted high byte is never written.
- WR16 pair=2, data=16'h8001 → E+1: we=1, wrn=5, wr=8'h01; E+2: we=1, wrn=4, wr=8'h80, done=1; E+3: req_ready=1.
- INC16 pair=3, rdw=16'hFFFF → writes wrn=7 wr=8'h00, then wrn=6 wr=8'h00. DEC16 pair=0, rdw=16'h0000 → writes 8'hFF to index 1, then 8'hFF to index 0.
- WR8 idx=3, data[7:0]=8'hA5 → E+1: we=1, wrn=3, wr=8'hA5, done=1; E+2: req_ready=1. Exactly one we pulse.
- Back-to-back INC16 on DE starting at 16'h00FF, with the bench register file model → DE=16'h0100, then 16'h0101. req_valid held high throughout; every accept occurs only while req_ready=1.
- REGWB_OAMBUG_EN defined: INC16 with rdw=16'hFE10 → oam_bug=1 in the WR_LO cycle. rdw=16'hFF00 → oam_bug stays 0.
